ycr1_memory_tb_wb_burst: RTL and testbench

- Parametrised Wishbone burst memory model for simulation benches; successor to the fixed 32-bit burst memory model.
- Adds configurable data width and base/size window, deterministic first-beat latency and stall pattern, linear and wrap bursts, and error termination.
- Sits behind the interconnect/cache Wishbone master port in the top-level bench.

---
 rtl/ycr1_memory_tb_wb_burst_if.sv | 28 ++
 rtl/ycr1_memory_tb_wb_burst.sv | 160 ++++++++++++++++
 tb/tb_ycr1_memory_tb_wb_burst.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ycr1_memory_tb_wb_burst_if.sv
// Wishbone burst port between a bench-side master and the burst memory model.
interface ycr1_memory_tb_wb_burst_if #(
    parameter int DW   = 32,
    parameter int BL_W = 10
);
    logic              wbd_mem_stb_i;
    logic [31:0]       wbd_mem_adr_i;
    logic              wbd_mem_we_i;
    logic [DW-1:0]     wbd_mem_dat_i;
    logic [DW/8-1:0]   wbd_mem_sel_i;
    logic [BL_W-1:0]   wbd_mem_bl_i;
    logic [DW-1:0]     wbd_mem_dat_o;
    logic              wbd_mem_ack_o;
    logic              wbd_mem_lack_o;
    logic              wbd_mem_err_o;

    modport master (
        output wbd_mem_stb_i, wbd_mem_adr_i, wbd_mem_we_i, wbd_mem_dat_i,
               wbd_mem_sel_i, wbd_mem_bl_i,
        input  wbd_mem_dat_o, wbd_mem_ack_o, wbd_mem_lack_o, wbd_mem_err_o
    );

    modport slave (
        input  wbd_mem_stb_i, wbd_mem_adr_i, wbd_mem_we_i, wbd_mem_dat_i,
               wbd_mem_sel_i, wbd_mem_bl_i,
        output wbd_mem_dat_o, wbd_mem_ack_o, wbd_mem_lack_o, wbd_mem_err_o
    );
endinterface

// File: rtl/ycr1_memory_tb_wb_burst.sv
// Parametrised Wishbone burst memory model: configurable first-beat latency,
// rotating stall pattern, linear/wrap bursts and error termination.
module ycr1_memory_tb_wb_burst #(
    parameter int          DW     = 32,
    parameter int          MEM_AW = 20,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int          BL_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 cfg_lat_i,
    input  logic [31:0]                cfg_stall_i,
    input  logic                       cfg_wrap_i,
    ycr1_memory_tb_wb_burst_if.slave   wbd
);
    localparam int          BW       = DW / 8;
    localparam int          OFF_W    = $clog2(BW);
    localparam logic [32:0] WIN_SIZE = 33'd1 << MEM_AW;

    typedef enum logic [2:0] {S_IDLE, S_LAT, S_DATA, S_ERR, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_ptr, r_win_base, r_wmask, r_stall;
    logic [BL_W-1:0]   r_bl, r_cnt;
    logic [3:0]        r_lat;
    logic              r_wrap;
    logic [DW-1:0]     r_dat_o;
    logic              r_ack, r_lack, r_err;
    logic [7:0]        r_mem [2**MEM_AW];

    logic              w_start, w_beat, w_ready, w_bad_req, w_ptr_oob;
    logic              w_ack_nxt, w_lack_nxt, w_err_nxt;
    logic [32:0]       w_adr_off, w_ptr_off;
    logic [31:0]       w_adr_al, w_wmask, w_ptr_lin;
    logic [MEM_AW-1:0] w_idx;
    logic [DW-1:0]     w_rdata;

    assign w_adr_al  = {wbd.wbd_mem_adr_i[31:OFF_W], {OFF_W{1'b0}}};
    assign w_adr_off = {1'b0, wbd.wbd_mem_adr_i} - {1'b0, BASE};
    assign w_wmask   = (32'(wbd.wbd_mem_bl_i) << OFF_W) - 32'd1;
    assign w_bad_req = (wbd.wbd_mem_bl_i == '0) || (w_adr_off >= WIN_SIZE) ||
                       (cfg_wrap_i && ((wbd.wbd_mem_bl_i & (wbd.wbd_mem_bl_i - 1'b1)) != '0));

    assign w_ptr_off = {1'b0, r_ptr} - {1'b0, BASE};
    assign w_ptr_oob = (w_ptr_off >= WIN_SIZE);
    assign w_idx     = w_ptr_off[MEM_AW-1:0];
    assign w_ptr_lin = r_ptr + 32'(BW);
    assign w_ready   = (r_stall == '0) ? 1'b1 : r_stall[0];

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < BW; i++)
            if (wbd.wbd_mem_sel_i[i]) w_rdata[8*i +: 8] = r_mem[w_idx + MEM_AW'(i)];
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_ack_nxt   = 1'b0;
        w_lack_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: if (wbd.wbd_mem_stb_i) begin
                w_start = 1'b1;
                if (w_bad_req) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = (cfg_lat_i != 4'd0) ? S_LAT : S_DATA;
                end
            end
            S_LAT: begin
                if (!wbd.wbd_mem_stb_i)  w_state_nxt = S_IDLE;
                else if (r_lat == 4'd1)  w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!wbd.wbd_mem_stb_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ready) begin
                    // A linear burst that walked off the window ends with err instead of ack.
                    if (!r_wrap && w_ptr_oob) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_beat    = 1'b1;
                        w_ack_nxt = 1'b1;
                        if (r_cnt == r_bl) begin
                            w_lack_nxt  = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_ERR:   w_state_nxt = S_DONE;
            S_DONE:  if (!wbd.wbd_mem_stb_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_lack  <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_lack  <= w_lack_nxt;
            r_err   <= w_err_nxt;
            if (w_beat && !wbd.wbd_mem_we_i) r_dat_o <= w_rdata;
        end
    end

    // The stall pattern advances through LAT as well, so latency and stall compose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall    <= cfg_stall_i;
            r_ptr      <= '0;
            r_win_base <= '0;
            r_wmask    <= '0;
            r_bl       <= '0;
            r_cnt      <= '0;
            r_lat      <= '0;
            r_wrap     <= 1'b0;
        end else if (w_start) begin
            r_stall    <= cfg_stall_i;
            r_ptr      <= w_adr_al;
            r_win_base <= w_adr_al & ~w_wmask;
            r_wmask    <= w_wmask;
            r_bl       <= wbd.wbd_mem_bl_i;
            r_cnt      <= {{(BL_W-1){1'b0}}, 1'b1};
            r_lat      <= cfg_lat_i;
            r_wrap     <= cfg_wrap_i;
        end else begin
            if (r_state == S_LAT || r_state == S_DATA) r_stall <= {r_stall[0], r_stall[31:1]};
            if (r_state == S_LAT) r_lat <= r_lat - 4'd1;
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                r_ptr <= r_wrap ? (r_win_base | (w_ptr_lin & r_wmask)) : w_ptr_lin;
            end
        end
    end

    // NOTE: the backing array has no reset; contents survive rst_n like a real memory.
    always_ff @(posedge clk) begin
        if (w_beat && wbd.wbd_mem_we_i)
            for (int i = 0; i < BW; i++)
                if (wbd.wbd_mem_sel_i[i]) r_mem[w_idx + MEM_AW'(i)] <= wbd.wbd_mem_dat_i[8*i +: 8];
    end

    assign wbd.wbd_mem_dat_o  = r_dat_o;
    assign wbd.wbd_mem_ack_o  = r_ack;
    assign wbd.wbd_mem_lack_o = r_lack;
    assign wbd.wbd_mem_err_o  = r_err;
endmodule

// File: tb/tb_ycr1_memory_tb_wb_burst.sv
// Scoreboard bench for the Wishbone burst memory model (DW=32, 4 KiB window at 0).
module tb_ycr1_memory_tb_wb_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_lat;
    logic [31:0] cfg_stall;
    logic        cfg_wrap;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        is_rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wq[$];
    int          acks, errs, lacks, first_c, last_c, min_gap;

    ycr1_memory_tb_wb_burst_if #(.DW(32), .BL_W(10)) bus ();

    ycr1_memory_tb_wb_burst #(.DW(32), .MEM_AW(12), .BASE(32'h0), .BL_W(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_lat_i   (cfg_lat),
        .cfg_stall_i (cfg_stall),
        .cfg_wrap_i  (cfg_wrap),
        .wbd         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_rd, input logic [31:0] d, input logic last);
        exp_t e;
        e.data = d; e.last = last; e.is_rd = is_rd;
        exp_q.push_back(e);
    endtask

    // Drives one burst; abort_after>0 drops stb (or pulses reset) after that many acks.
    task automatic burst(input logic we, input logic [31:0] adr, input int bl,
                         input logic [3:0] sel, input logic wrap, input logic [3:0] lat,
                         input logic [31:0] stall, input int abort_after, input logic abort_rst);
        int   k, c, tail;
        bit   done;
        exp_t e;
        acks = 0; errs = 0; lacks = 0; first_c = -1; last_c = -1; min_gap = 1000;
        k = 0; c = 0; tail = 0; done = 0;
        cfg_lat = lat; cfg_stall = stall; cfg_wrap = wrap;
        bus.wbd_mem_we_i  = we;
        bus.wbd_mem_adr_i = adr;
        bus.wbd_mem_sel_i = sel;
        bus.wbd_mem_bl_i  = 10'(bl);
        bus.wbd_mem_dat_i = (wq.size() > 0) ? wq[0] : 32'h0;
        bus.wbd_mem_stb_i = 1'b1;
        while (!done) begin
            @(posedge clk); #1;
            if (bus.wbd_mem_ack_o) begin
                acks++;
                if (last_c >= 0 && c - last_c < min_gap) min_gap = c - last_c;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (exp_q.size() == 0) begin
                    check("sb_extra_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_rd) check("rdata", bus.wbd_mem_dat_o, e.data);
                    check("lack_flag", 32'(bus.wbd_mem_lack_o), 32'(e.last));
                end
                k++;
                bus.wbd_mem_dat_i = (k < wq.size()) ? wq[k] : 32'h0;
            end else if (bus.wbd_mem_lack_o) begin
                check("lack_without_ack", 32'd0, 32'd1);
            end
            if (bus.wbd_mem_err_o)  errs++;
            if (bus.wbd_mem_lack_o) lacks++;
            if (tail > 0) begin
                tail--;
                if (tail == 0) done = 1;
            end else if (bus.wbd_mem_lack_o || bus.wbd_mem_err_o ||
                         (abort_after > 0 && acks == abort_after)) begin
                if (abort_after > 0 && acks == abort_after && abort_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_ack",  32'(bus.wbd_mem_ack_o),  32'd0);
                    check("rst_lack", 32'(bus.wbd_mem_lack_o), 32'd0);
                    check("rst_err",  32'(bus.wbd_mem_err_o),  32'd0);
                    check("rst_dat",  bus.wbd_mem_dat_o,       32'd0);
                    #2 rst_n = 1'b1;
                end
                bus.wbd_mem_stb_i = 1'b0;
                tail = 4;
            end
            c++;
            if (c > 200 && !done) begin
                check("timeout", 32'd1, 32'd0);
                bus.wbd_mem_stb_i = 1'b0;
                done = 1;
            end
        end
        exp_q.delete();
        wq.delete();
    endtask

    initial begin
        rst_n = 1'b0; cfg_lat = '0; cfg_stall = '0; cfg_wrap = 1'b0;
        bus.wbd_mem_stb_i = 1'b0; bus.wbd_mem_adr_i = '0; bus.wbd_mem_we_i = 1'b0;
        bus.wbd_mem_dat_i = '0;   bus.wbd_mem_sel_i = '0; bus.wbd_mem_bl_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack",  32'(bus.wbd_mem_ack_o),  32'd0);
        check("reset_lack", 32'(bus.wbd_mem_lack_o), 32'd0);
        check("reset_err",  32'(bus.wbd_mem_err_o),  32'd0);
        check("reset_dat",  bus.wbd_mem_dat_o,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Linear write then read, no latency, always ready.
        wq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 1);
        burst(1, 32'h100, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t1w_acks", acks, 4); check("t1w_first", first_c, 1);
        check("t1w_last", last_c, 4); check("t1w_lacks", lacks, 1);
        push(1, 32'h1111_1111, 0); push(1, 32'h2222_2222, 0);
        push(1, 32'h3333_3333, 0); push(1, 32'h4444_4444, 1);
        burst(0, 32'h100, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t1r_acks", acks, 4); check("t1r_first", first_c, 1); check("t1r_gap", min_gap, 1);

        // Latency 3 with alternating stall pattern.
        push(1, 32'h1111_1111, 0); push(1, 32'h2222_2222, 0);
        push(1, 32'h3333_3333, 0); push(1, 32'h4444_4444, 1);
        burst(0, 32'h100, 4, 4'hF, 0, 4'd3, 32'hAAAA_AAAA, 0, 0);
        check("t2_acks", acks, 4); check("t2_first", first_c, 4);
        check("t2_last", last_c, 10); check("t2_gap", min_gap, 2); check("t2_lacks", lacks, 1);

        // Wrap burst order 0x108, 0x10C, 0x100, 0x104; non-power-of-two wrap errors.
        push(1, 32'h3333_3333, 0); push(1, 32'h4444_4444, 0);
        push(1, 32'h1111_1111, 0); push(1, 32'h2222_2222, 1);
        burst(0, 32'h108, 4, 4'hF, 1, 4'd0, 32'h0, 0, 0);
        check("t3_acks", acks, 4); check("t3_lacks", lacks, 1);
        burst(0, 32'h108, 3, 4'hF, 1, 4'd0, 32'h0, 0, 0);
        check("t3e_acks", acks, 0); check("t3e_errs", errs, 1);

        // Byte-lane writes and reads.
        wq = '{32'h0}; push(0, 0, 1);
        burst(1, 32'h0, 1, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        wq = '{32'hAABB_CCDD}; push(0, 0, 1);
        burst(1, 32'h0, 1, 4'b0101, 0, 4'd0, 32'h0, 0, 0);
        push(1, 32'h00BB_00DD, 1);
        burst(0, 32'h0, 1, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t4_acks", acks, 1);
        push(1, 32'h0000_00DD, 1);
        burst(0, 32'h0, 1, 4'b0011, 0, 4'd0, 32'h0, 0, 0);

        // Window edge: linear burst runs off the top; out-of-window start; bl=0.
        wq = '{32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003, 32'h5A5A_0004};
        push(0, 0, 0); push(0, 0, 0);
        burst(1, 32'hFF8, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t5_acks", acks, 2); check("t5_errs", errs, 1); check("t5_lacks", lacks, 0);
        push(1, 32'h5A5A_0001, 0); push(1, 32'h5A5A_0002, 1);
        burst(0, 32'hFF8, 2, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        push(1, 32'h00BB_00DD, 1);
        burst(0, 32'h0, 1, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        burst(0, 32'h2000, 2, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t5o_acks", acks, 0); check("t5o_errs", errs, 1);
        burst(0, 32'h100, 0, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t5z_acks", acks, 0); check("t5z_errs", errs, 1);

        // Abort by stb drop, then reset mid-burst; memory must survive both.
        wq = '{32'h0, 32'h0, 32'h0, 32'h0};
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 1);
        burst(1, 32'h200, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        wq = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004,
               32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007, 32'hC0DE_0008};
        push(0, 0, 0); push(0, 0, 0);
        burst(1, 32'h200, 8, 4'hF, 0, 4'd0, 32'h0, 2, 0);
        check("t6a_acks", acks, 2); check("t6a_lacks", lacks, 0);
        push(1, 32'hC0DE_0001, 0); push(1, 32'hC0DE_0002, 0);
        push(1, 32'h0, 0);         push(1, 32'h0, 1);
        burst(0, 32'h200, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        push(1, 32'h1111_1111, 0); push(1, 32'h2222_2222, 0);
        burst(0, 32'h100, 8, 4'hF, 0, 4'd0, 32'h0, 2, 1);
        check("t6r_acks", acks, 2); check("t6r_lacks", lacks, 0); check("t6r_errs", errs, 0);
        push(1, 32'h1111_1111, 0); push(1, 32'h2222_2222, 0);
        push(1, 32'h3333_3333, 0); push(1, 32'h4444_4444, 1);
        burst(0, 32'h100, 4, 4'hF, 0, 4'd0, 32'h0, 0, 0);
        check("t6k_acks", acks, 4);
        push(1, 32'hC0DE_0001, 0); push(1, 32'hC0DE_0002, 1);
        burst(0, 32'h200, 2, 4'hF, 0, 4'd0, 32'h0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
